uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 40 ++++
 rtl/uart_tx_arb.sv | 118 +++++++++++
 tb/tb_uart_tx_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART TX byte-stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_MAX_BURST  = 16;

    // Index width for an N-entry one-hot vector; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; win_oh is all-zero when req is all-zero.
//
// Ports: req (request vector), ptr (search start index),
//        win_oh (one-hot winner), win_idx (binary winner index).
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    always_comb begin : pick
        logic found;
        int   j;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr is always < NUM_REQ, so one subtraction is enough to wrap.
            j = int'(ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter merging NUM_REQ byte streams into one UART TX FIFO write port.
// Latency: 1 arbitration cycle (IDLE) before the first byte of a grant; bytes then pass combinationally.
// Backpressure: fifo_full_i or owner valid low stalls the write; grant and byte count are held.
//
// Ports: clk_i/rst_ni (clock, async active-low reset); req_valid_i/req_data_i/req_last_i/
//        req_ready_o (per-requester byte stream); fifo_full_i/fifo_we_o/fifo_din_o (TX FIFO
//        write side); grant_o (one-hot owner, zero when idle); busy_o (transfer in progress).
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int MAX_BURST  = UART_MAX_BURST
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_we_o,
    output logic [DATA_WIDTH-1:0]         fifo_din_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;

    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 owner_vld;
    logic                 owner_last;
    logic [DATA_WIDTH-1:0] owner_dat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_rr_pick (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    assign owner_vld  = req_valid_i[owner_q];
    assign owner_last = req_last_i[owner_q];
    assign owner_dat  = req_data_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
    assign cnt_inc    = cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        fifo_we_o   = 1'b0;
        fifo_din_o  = '0;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                // Register the winner only; the first byte moves in XFER.
                if (|req_valid_i) begin
                    state_d = XFER;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (owner_vld && !fifo_full_i) begin
                    fifo_we_o   = 1'b1;
                    fifo_din_o  = owner_dat;
                    req_ready_o = grant_q;
                    cnt_d       = cnt_inc;
                    // End of packet and burst cap may coincide; either ends the grant once.
                    if (owner_last || (cnt_inc == CW'(MAX_BURST))) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  valid, last, ready, grant;
    logic [N*DW-1:0] data;
    logic          full, we, busy;
    logic [DW-1:0] din;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (valid),
        .req_data_i  (data),
        .req_last_i  (last),
        .req_ready_o (ready),
        .fifo_full_i (full),
        .fifo_we_o   (we),
        .fifo_din_o  (din),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    int n_tests, n_fail;

    // Per-requester pending bytes: bit 8 is the last flag.
    logic [8:0] pq    [N][$];
    logic [7:0] exp_q [N][$];
    logic [7:0] got_q [N][$];
    int         gseq[$];

    int vpct[N];
    int full_pct;
    int full_at_wr, full_len;
    int drop_k, drop_at_wr, drop_len;
    int wr_cnt;

    // Reference model: owner (-1 = no owner), round-robin pointer, burst count.
    int m_owner, m_ptr, m_cnt;
    logic [N-1:0] prev_grant;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit pending();
        for (int k = 0; k < N; k++) if (pq[k].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_ctrl();
        for (int k = 0; k < N; k++) begin
            pq[k].delete();
            exp_q[k].delete();
            got_q[k].delete();
            vpct[k] = 100;
        end
        gseq.delete();
        full_pct   = 0;
        full_at_wr = -1;
        full_len   = 0;
        drop_k     = -1;
        drop_at_wr = 0;
        drop_len   = 0;
        wr_cnt     = 0;
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_ptr      = 0;
        m_cnt      = 0;
        prev_grant = '0;
    endtask

    task automatic add_byte(input int k, input logic [7:0] b, input logic l);
        pq[k].push_back({l, b});
        exp_q[k].push_back(b);
    endtask

    task automatic add_pkt(input int k, input int len, input logic with_last);
        for (int i = 0; i < len; i++)
            add_byte(k, 8'($urandom), with_last && (i == len - 1));
    endtask

    // One clock: drive at negedge, check #1 later, then advance the model for the next posedge.
    task automatic step();
        logic [8:0]    h;
        logic          v, acc, lb;
        logic [N-1:0]  e_grant, e_rdy;
        logic          e_busy, e_we;
        logic [DW-1:0] e_din;
        int            w;
        @(negedge clk);
        if (full_at_wr >= 0 && full_len > 0 && wr_cnt >= full_at_wr) begin
            full = 1'b1;
            full_len--;
        end else begin
            full = ($urandom_range(99) < full_pct);
        end
        for (int k = 0; k < N; k++) begin
            v = (pq[k].size() > 0) && ($urandom_range(99) < vpct[k]);
            if (k == drop_k && drop_len > 0 && wr_cnt >= drop_at_wr) begin
                v = 1'b0;
                drop_len--;
            end
            valid[k] = v;
            if (v) begin
                h = pq[k][0];
                data[k*DW +: DW] = h[7:0];
                last[k] = h[8];
            end else begin
                data[k*DW +: DW] = 8'($urandom);
                last[k] = 1'($urandom);
            end
        end
        #1;
        e_grant = '0; e_rdy = '0; e_busy = 1'b0; e_we = 1'b0; e_din = '0; acc = 1'b0; lb = 1'b0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy = 1'b1;
            acc = valid[m_owner] && !full;
            if (acc) begin
                e_we = 1'b1;
                e_rdy[m_owner] = 1'b1;
                e_din = data[m_owner*DW +: DW];
                lb = last[m_owner];
            end
        end
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy",  32'(busy),  32'(e_busy));
        chk("we",    32'(we),    32'(e_we));
        chk("din",   32'(din),   32'(e_din));
        chk("ready", 32'(ready), 32'(e_rdy));
        if (grant != '0 && prev_grant == '0) gseq.push_back(oh2idx(grant));
        prev_grant = grant;
        if (we && oh2idx(grant) >= 0) got_q[oh2idx(grant)].push_back(din);
        if (acc) begin
            void'(pq[m_owner].pop_front());
            wr_cnt++;
        end
        if (m_owner < 0) begin
            if (valid != '0) begin
                w = -1;
                for (int i = 0; i < N; i++)
                    if (w < 0 && valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
                m_owner = w;
                m_ptr   = (w + 1) % N;
                m_cnt   = 0;
            end
        end else if (acc) begin
            m_cnt++;
            if (lb || m_cnt == MB) m_owner = -1;
        end
    endtask

    task automatic run(input string tag, input int budget);
        int c;
        c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_timeout"}, 32'(pending()), 32'd0);
        step();
        step();
    endtask

    task automatic check_integrity(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_len%0d", tag, k), got_q[k].size(), exp_q[k].size());
            for (int i = 0; i < exp_q[k].size() && i < got_q[k].size(); i++)
                chk($sformatf("%s_dat%0d_%0d", tag, k, i), 32'(got_q[k][i]), 32'(exp_q[k][i]));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        valid = '0;
        full  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_ctrl();
    endtask

    function automatic int gs(input int i);
        return (gseq.size() > i) ? gseq[i] : 99;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        valid   = '0;
        last    = '0;
        data    = '0;
        full    = 1'b0;
        clear_ctrl();
        model_reset();

        // Reset state
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_we",    32'(we),    32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_din",   32'(din),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single 3-byte packet from requester 0
        add_byte(0, 8'h11, 1'b0);
        add_byte(0, 8'h22, 1'b0);
        add_byte(0, 8'h33, 1'b1);
        run("p3", 200);
        chk("p3_ngrants", gseq.size(), 1);
        chk("p3_g0", gs(0), 0);
        check_integrity("p3");

        // All four requesters, 2-byte packets: strict 0,1,2,3 order with bubbles
        pulse_reset();
        for (int k = 0; k < N; k++) add_pkt(k, 2, 1'b1);
        run("rr4", 200);
        chk("rr4_ngrants", gseq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rr4_g%0d", i), gs(i), i);
        check_integrity("rr4");

        // FIFO full for 5 cycles mid-packet on requester 1
        pulse_reset();
        add_pkt(1, 4, 1'b1);
        full_at_wr = 1;
        full_len   = 5;
        run("full", 200);
        chk("full_g0", gs(0), 1);
        check_integrity("full");

        // Burst cap: requester 2 streams 40 bytes without last, requester 3 waiting
        pulse_reset();
        add_pkt(2, 40, 1'b0);
        add_pkt(3, 2, 1'b1);
        run("cap", 400);
        chk("cap_ngrants", gseq.size(), 4);
        chk("cap_g0", gs(0), 2);
        chk("cap_g1", gs(1), 3);
        chk("cap_g2", gs(2), 2);
        chk("cap_g3", gs(3), 2);
        check_integrity("cap");

        // Reset mid-transfer
        pulse_reset();
        add_pkt(0, 20, 1'b1);
        repeat (6) step();
        @(negedge clk);
        #1;
        chk("mrst_busy_pre", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_grant", 32'(grant), 32'd0);
        chk("mrst_busy",  32'(busy),  32'd0);
        chk("mrst_we",    32'(we),    32'd0);
        chk("mrst_ready", 32'(ready), 32'd0);
        chk("mrst_din",   32'(din),   32'd0);
        valid = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_ctrl();
        add_pkt(2, 3, 1'b1);
        add_pkt(3, 2, 1'b1);
        run("mrst", 200);
        chk("mrst_g0", gs(0), 2);
        check_integrity("mrst");

        // Owner drops valid for 3 cycles while others request
        pulse_reset();
        add_pkt(1, 6, 1'b1);
        add_pkt(2, 2, 1'b1);
        add_pkt(3, 2, 1'b1);
        drop_k     = 1;
        drop_at_wr = 2;
        drop_len   = 3;
        run("drop", 300);
        chk("drop_g0", gs(0), 1);
        chk("drop_g1", gs(1), 2);
        chk("drop_g2", gs(2), 3);
        check_integrity("drop");

        // Randomized traffic, pointer carried across rounds
        pulse_reset();
        for (int r = 0; r < 4; r++) begin
            clear_ctrl();
            for (int k = 0; k < N; k++) begin
                vpct[k] = $urandom_range(100, 40);
                for (int p = 0; p < int'($urandom_range(3)); p++)
                    add_pkt(k, $urandom_range(20, 1), 1'b1);
            end
            full_pct = $urandom_range(40);
            run($sformatf("rnd%0d", r), 4000);
            check_integrity($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
